lc3_fetch_sequencer: RTL and testbench
======================================

# lc3_fetch_sequencer

Control FSM that sequences the LC-3 program counter and instruction fetch. It drives the PC block's `ldPC`/`selPC` controls, the PC-to-bus gate, MAR/IR loads and a memory read handshake. It then hands each fetched instruction to decode and waits for execute to finish. It sits between the PC/MAR/IR datapath registers and the execute unit, and is the only source of PC updates.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum F2 cycles spent waiting for `mem_ready` before a fetch error (≥2).
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high; forces IDLE and clears all state.
- `run`  in  1: level; permits starting a new instruction.
- `mem_ready`  in  1: memory has read data valid for the current MAR.
- `exec_done`  in  1: execute unit has finished the current instruction.
- `redirect`  in  1: with `exec_done`, the PC must be loaded from a non-incremented source.
- `redirect_src`  in  1: 0 = take PC from eabOut (`selPC`=01); 1 = take PC from Bus (`selPC`=10).
- `halt_req`  in  1: with `exec_done`, the instruction was a HALT trap.
- `ldPC`  out  1: PC register load enable.
- `selPC`  out  2: PC source mux select (00 = PC+1, 01 = eabOut, 10 = Bus).
- `gatePC`  out  1: drive PC onto Bus.
- `ldMAR`  out  1: load MAR from Bus.
- `mem_req`  out  1: memory read request.
- `ldIR`  out  1: load IR from memory data.
- `decode_valid`  out  1: IR holds a new instruction (one-cycle pulse).
- `halted`  out  1: in HALT state.
- `mem_err`  out  1: sticky fetch-timeout flag.
- `instr_count`  out  `CNT_W`: retired instructions, modulo 2^CNT_W.

## Operation
- States: IDLE, F1, F2, F3, DEC, EXEC, REDIR, HALT. All outputs except `instr_count` and `mem_err` are Moore decodes of state. Any output not listed for a state is 0, and `selPC` is 00.
- IDLE: no outputs. Go to F1 when `run`=1.
- F1: `gatePC`=1, `ldMAR`=1, `ldPC`=1, `selPC`=00. MAR captures the old PC and PC becomes PC+1. Always go to F2.
- F2: `mem_req`=1. Go to F3 if `mem_ready`=1. A wait counter clears on entry and increments each F2 cycle without `mem_ready`. If the TIMEOUT-th consecutive F2 cycle still sees no `mem_ready`, go to HALT and set `mem_err`. `mem_ready` on the TIMEOUT-th cycle is accepted.
- F3: `ldIR`=1. Go to DEC.
- DEC: `decode_valid`=1. Go to EXEC.
- EXEC: wait for `exec_done`. `redirect`, `redirect_src` and `halt_req` are sampled only when `exec_done`=1. When `exec_done`=1:
  - `halt_req`=1 → HALT. This has priority over `redirect`.
  - otherwise `redirect`=1 → REDIR.
  - otherwise → F1 if `run`=1, else IDLE.
- REDIR: `ldPC`=1, `selPC` = (`redirect_src` ? 10 : 01), using the value of `redirect_src` latched in EXEC. Then go to F1 if `run`=1, else IDLE.
- HALT: `halted`=1. The only exit is `reset`.
- `instr_count` increments by 1 on each completed instruction and wraps from all-ones to 0. A completed instruction is:
  - an EXEC exit to F1, IDLE or HALT (including a HALT instruction), or
  - a REDIR exit.
- A timeout HALT does not increment `instr_count`.
- Deasserting `run` mid-instruction does not abort it. The instruction finishes and the block parks in IDLE.
- `selPC`=11 is never driven.

## Timing
- Reset (asynchronous): state = IDLE; every output = 0, including `instr_count`, `mem_err` and `selPC`; the wait counter is cleared.
- Reset asserted mid-fetch or mid-execute aborts immediately. Outputs go to 0 without waiting for a clock edge.
- Minimum instruction latency is 5 cycles (F1, F2, F3, DEC, EXEC). This holds when `mem_ready`=1 in the first F2 cycle and `exec_done`=1 in the first EXEC cycle. A redirect adds 1 cycle.
- The `run` 0→1 transition reaches F1 on the next edge, so the first `ldPC` is asserted 1 cycle after `run` is seen.
- `decode_valid` is high exactly 1 cycle per fetched instruction, 1 cycle after `ldIR`.
- `mem_req` stays high continuously from F2 entry through the cycle `mem_ready` is sampled; it drops in F3.
- `instr_count` updates on the same edge as the completing state transition.

## Test plan
- Reset then `run`=1, `mem_ready` and `exec_done` tied 1 for 3 instructions → per instruction: `ldPC`=1 with `selPC`=00 in F1, `ldIR` in F3, `decode_valid` in DEC. After 15 cycles in EXEC-exit order, `instr_count`=3.
- In F2, hold `mem_ready`=0 for 3 cycles then 1 → `mem_req` high for 4 cycles, `ldIR` on the next cycle, `mem_err`=0.
- `exec_done`=1 with `redirect`=1: first `redirect_src`=0, then `redirect_src`=1 → REDIR asserts `ldPC` with `selPC`=01, then with `selPC`=10; count +1 per instruction.
- `exec_done`, `halt_req` and `redirect` all 1 together → HALT, `halted`=1, `ldPC` never asserted, count +1. Toggling `run` has no effect until `reset`.
- `TIMEOUT`=4, `mem_ready`=0 forever → exactly 4 F2 cycles, then `halted`=1 and `mem_err`=1 with count unchanged. Also: `mem_ready`=1 on the 4th cycle → normal F3.
- Preload count to 16'hFFFF via 65535 no-op instructions (or use `CNT_W`=4 with 15); the next completion wraps to 0. Separately, assert `reset` in F2 → all outputs 0 at once, and the state after release is IDLE.

Source files
------------

// File: rtl/lc3_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// lc3_fetch_sequencer
//
// Control FSM sequencing the LC-3 program counter and instruction fetch.
// Drives PC load/select, the PC-to-bus gate, MAR/IR loads and a memory read
// handshake, then hands the fetched instruction to decode and waits for the
// execute unit to finish. This block is the only source of PC updates.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | parked, waiting for run
// F1    | PC -> bus -> MAR, PC <= PC+1
// F2    | memory read request, wait for mem_ready (bounded by TIMEOUT)
// F3    | IR <= memory data
// DEC   | decode_valid pulse
// EXEC  | wait for exec_done, pick halt / redirect / next fetch
// REDIR | PC <= eabOut or Bus, chosen by redirect_src captured in EXEC
// HALT  | halted; left only through reset
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   run                        permits starting a new instruction
//   mem_ready                  memory read data valid for current MAR
//   exec_done                  execute unit finished current instruction
//   redirect, redirect_src     non-incremented PC load and its source
//   halt_req                   finished instruction was a HALT trap
//   ldPC, selPC                PC load enable / source (00 PC+1, 01 eab, 10 bus)
//   gatePC, ldMAR              PC onto bus, MAR load
//   mem_req, ldIR              memory read request, IR load
//   decode_valid               one-cycle pulse, IR holds a new instruction
//   halted, mem_err            in HALT, sticky fetch-timeout flag
//   instr_count                retired instructions, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module lc3_fetch_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             mem_ready,
    input  logic             exec_done,
    input  logic             redirect,
    input  logic             redirect_src,
    input  logic             halt_req,
    output logic             ldPC,
    output logic [1:0]       selPC,
    output logic             gatePC,
    output logic             ldMAR,
    output logic             mem_req,
    output logic             ldIR,
    output logic             decode_valid,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_F3,
        S_DEC,
        S_EXEC,
        S_REDIR,
        S_HALT
    } state_t;

    localparam int              WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;
    logic              timeout_hit;

    // Next-state decode; retire marks an instruction completing on this edge.
    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:  if (run) state_nxt = S_F1;
            S_F1:    state_nxt = S_F2;
            S_F2: begin
                if (mem_ready) begin
                    state_nxt = S_F3;
                end else if (wait_cnt == '0) begin
                    state_nxt   = S_HALT;
                    timeout_hit = 1'b1;
                end
            end
            S_F3:    state_nxt = S_DEC;
            S_DEC:   state_nxt = S_EXEC;
            S_EXEC: begin
                if (exec_done) begin
                    if (halt_req) begin
                        state_nxt = S_HALT;
                        retire    = 1'b1;
                    end else if (redirect) begin
                        state_nxt = S_REDIR;
                    end else begin
                        state_nxt = run ? S_F1 : S_IDLE;
                        retire    = 1'b1;
                    end
                end
            end
            S_REDIR: begin
                state_nxt = run ? S_F1 : S_IDLE;
                retire    = 1'b1;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is a clean Moore
    // decode of the state being entered. selPC for REDIR is taken from
    // redirect_src on the EXEC exit edge, which is where it gets latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            ldPC         <= 1'b0;
            selPC        <= 2'b00;
            gatePC       <= 1'b0;
            ldMAR        <= 1'b0;
            mem_req      <= 1'b0;
            ldIR         <= 1'b0;
            decode_valid <= 1'b0;
            halted       <= 1'b0;
            mem_err      <= 1'b0;
            instr_count  <= '0;
        end else begin
            state <= state_nxt;

            // Down-counter: loaded on F2 entry, terminal count 0 means the
            // current F2 cycle is the TIMEOUT-th one.
            if (state_nxt == S_F2 && state != S_F2) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == S_F2 && !mem_ready && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            ldPC         <= (state_nxt == S_F1) || (state_nxt == S_REDIR);
            selPC        <= (state_nxt == S_REDIR) ? (redirect_src ? 2'b10 : 2'b01)
                                                   : 2'b00;
            gatePC       <= (state_nxt == S_F1);
            ldMAR        <= (state_nxt == S_F1);
            mem_req      <= (state_nxt == S_F2);
            ldIR         <= (state_nxt == S_F3);
            decode_valid <= (state_nxt == S_DEC);
            halted       <= (state_nxt == S_HALT);

            if (timeout_hit) mem_err <= 1'b1;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lc3_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lc3_fetch_sequencer
//
// Directed stimulus for lc3_fetch_sequencer (TIMEOUT=4, CNT_W=4). Each step
// drives inputs on the falling edge and queues the hand-derived output vector
// expected after the following rising edge; an independent monitor pops and
// compares one entry per cycle. Asynchronous reset effects are checked
// directly while reset is held.
// -----------------------------------------------------------------------------
module tb_lc3_fetch_sequencer;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          run, mem_ready, exec_done, redirect, redirect_src, halt_req;
    logic          ldPC, gatePC, ldMAR, mem_req, ldIR, decode_valid, halted, mem_err;
    logic [1:0]    selPC;
    logic [CW-1:0] instr_count;

    lc3_fetch_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .mem_ready    (mem_ready),
        .exec_done    (exec_done),
        .redirect     (redirect),
        .redirect_src (redirect_src),
        .halt_req     (halt_req),
        .ldPC         (ldPC),
        .selPC        (selPC),
        .gatePC       (gatePC),
        .ldMAR        (ldMAR),
        .mem_req      (mem_req),
        .ldIR         (ldIR),
        .decode_valid (decode_valid),
        .halted       (halted),
        .mem_err      (mem_err),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    typedef enum {E_IDLE, E_F1, E_F2, E_F3, E_DEC, E_EXEC, E_REDIR, E_HALT} est_t;

    typedef struct packed {
        logic          ld_pc;
        logic [1:0]    sel;
        logic          gate;
        logic          ld_mar;
        logic          mreq;
        logic          ld_ir;
        logic          dv;
        logic          hlt;
        logic          err;
        logic [CW-1:0] cnt;
    } obs_t;

    typedef struct {
        int   id;
        obs_t v;
    } exp_t;

    exp_t          sb[$];
    int            checks  = 0;
    int            errors  = 0;
    int            step_id = 0;
    logic [CW-1:0] cnt;
    logic          err_exp;
    obs_t          actual;

    assign actual = {ldPC, selPC, gatePC, ldMAR, mem_req, ldIR, decode_valid,
                     halted, mem_err, instr_count};

    function automatic obs_t mk(est_t st, logic [1:0] sel, logic [CW-1:0] c, logic e);
        obs_t o;
        o     = '0;
        o.cnt = c;
        o.err = e;
        case (st)
            E_F1:    begin o.ld_pc = 1'b1; o.gate = 1'b1; o.ld_mar = 1'b1; end
            E_F2:    o.mreq  = 1'b1;
            E_F3:    o.ld_ir = 1'b1;
            E_DEC:   o.dv    = 1'b1;
            E_REDIR: begin o.ld_pc = 1'b1; o.sel = sel; end
            E_HALT:  o.hlt   = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // Monitor: one queued expectation per rising edge.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (actual !== e.v) begin
                    errors++;
                    $display("FAIL step %0d outputs got %b want %b", e.id, actual, e.v);
                end
            end
        end
    end

    task automatic step(input logic r, input logic mr, input logic ed, input logic rd,
                        input logic rs, input logic hr, input est_t st,
                        input logic [1:0] sel);
        exp_t e;
        @(negedge clk);
        run          = r;
        mem_ready    = mr;
        exec_done    = ed;
        redirect     = rd;
        redirect_src = rs;
        halt_req     = hr;
        step_id++;
        e.id = step_id;
        e.v  = mk(st, sel, cnt, err_exp);
        sb.push_back(e);
    endtask

    // From F1: fetch with immediate mem_ready, then exec_done on first EXEC cycle.
    task automatic run_instr(input logic r_body, input logic r_end);
        step(r_body, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F2,   2'b00);
        step(r_body, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F3,   2'b00);
        step(r_body, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_DEC,  2'b00);
        step(r_body, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_EXEC, 2'b00);
        cnt = cnt + 1'b1;
        step(r_end, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, r_end ? E_F1 : E_IDLE, 2'b00);
    endtask

    task automatic check_now(input int id, input obs_t want);
        checks++;
        if (actual !== want) begin
            errors++;
            $display("FAIL async_reset %0d outputs got %b want %b", id, actual, want);
        end
    endtask

    task automatic do_reset(input int id);
        @(negedge clk);
        reset        = 1'b1;
        run          = 1'b0;
        mem_ready    = 1'b0;
        exec_done    = 1'b0;
        redirect     = 1'b0;
        redirect_src = 1'b0;
        halt_req     = 1'b0;
        #1;
        cnt     = '0;
        err_exp = 1'b0;
        check_now(id, mk(E_IDLE, 2'b00, '0, 1'b0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        run          = 1'b0;
        mem_ready    = 1'b0;
        exec_done    = 1'b0;
        redirect     = 1'b0;
        redirect_src = 1'b0;
        halt_req     = 1'b0;
        cnt          = '0;
        err_exp      = 1'b0;
        #3;
        check_now(0, mk(E_IDLE, 2'b00, '0, 1'b0));
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back instructions, all handshakes immediate; last parks in IDLE.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_F1, 2'b00);
        run_instr(1'b1, 1'b1);
        run_instr(1'b1, 1'b1);
        run_instr(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, 2'b00);

        // Memory wait states: ready arrives on the TIMEOUT-th F2 cycle.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F1,   2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F2,   2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F2,   2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F2,   2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F2,   2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F3,   2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_DEC,  2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_EXEC, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, E_EXEC, 2'b00);
        // Redirect from eabOut, then from Bus.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_REDIR, 2'b01);
        cnt = cnt + 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_F1,   2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F2,   2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F3,   2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_DEC,  2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_EXEC, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, E_REDIR, 2'b10);
        cnt = cnt + 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F1,   2'b00);
        // run dropped mid-instruction: it completes, then parks.
        run_instr(1'b0, 1'b0);

        // Count 6 -> 15 -> wraps to 0 on the tenth completion.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F1, 2'b00);
        for (int k = 0; k < 10; k++) begin
            run_instr(1'b1, (k < 9) ? 1'b1 : 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 2'b00);

        // HALT trap with redirect also asserted: halt wins, counts, sticks.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F1,   2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F2,   2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F3,   2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_DEC,  2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_EXEC, 2'b00);
        cnt = cnt + 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, E_HALT, 2'b00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_HALT, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_HALT, 2'b00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_HALT, 2'b00);
        do_reset(1);

        // Fetch timeout after one good instruction: count stays at 1.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F1, 2'b00);
        run_instr(1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F2, 2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F2, 2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F2, 2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F2, 2'b00);
        err_exp = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_HALT, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_HALT, 2'b00);
        do_reset(2);

        // Reset asserted in F2 clears everything immediately; restart from IDLE.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F1, 2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F2, 2'b00);
        do_reset(3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F1,   2'b00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F2,   2'b00);

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
